// File: rtl/shift_reg_sequencer.sv
// Command-driven sequencer that issues ctrl/d cycles to a downstream universal shift register.
// Optional rotate-through-q feature enabled by defining SEQ_ROTATE_EN.
module shift_reg_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic             cmd_rot,
  input  logic [WIDTH-1:0] q,
  output logic [1:0]       ctrl,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LEFT  = 2'b01;
  localparam logic [1:0] OP_RIGHT = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fill_q, fill_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
`ifdef SEQ_ROTATE_EN
  logic             rot_q, rot_d;
`endif

  // Unknown or X op codes collapse to hold.
  function automatic logic [1:0] op_code(input logic [1:0] op);
    case (op)
      OP_LEFT, OP_RIGHT, OP_LOAD: op_code = op;
      default:                    op_code = OP_HOLD;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] d_val(input logic [1:0] op,
                                             input logic [WIDTH-1:0] data,
                                             input logic fill);
    case (op)
      OP_LOAD:  d_val = data;
      OP_LEFT:  d_val = WIDTH'(fill);
      OP_RIGHT: d_val = {fill, {(WIDTH-1){1'b0}}};
      default:  d_val = '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      op_q    <= OP_HOLD;
      data_q  <= '0;
      fill_q  <= 1'b0;
      ctrl_q  <= OP_HOLD;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef SEQ_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      ctrl_q  <= ctrl_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef SEQ_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  // Next state plus next registered outputs, computed for the upcoming cycle.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    data_d  = data_q;
    fill_d  = fill_q;
    ctrl_d  = OP_HOLD;
    dout_d  = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;
`ifdef SEQ_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          fill_d = cmd_fill;
          busy_d = 1'b1;
`ifdef SEQ_ROTATE_EN
          rot_d  = cmd_rot && (cmd_op == OP_LEFT || cmd_op == OP_RIGHT);
`endif
          if (cmd_op == OP_LOAD || cmd_count != '0) begin
            state_d = ST_EXEC;
            rem_d   = (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_count;
            ctrl_d  = op_code(cmd_op);
            dout_d  = d_val(op_code(cmd_op), cmd_data, cmd_fill);
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_EXEC: begin
        busy_d = 1'b1;
        if (rem_q <= CNT_W'(1)) begin
          state_d = ST_DONE;
          rem_d   = '0;
          done_d  = 1'b1;
        end else begin
          rem_d  = rem_q - CNT_W'(1);
          ctrl_d = op_code(op_q);
          dout_d = d_val(op_code(op_q), data_q, fill_q);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign cmd_ready = ready_q;
  assign ctrl      = ctrl_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef SEQ_ROTATE_EN
  // Rotate feeds the register's outgoing edge bit straight back in.
  always_comb begin
    d = dout_q;
    if (rot_q && state_q == ST_EXEC) begin
      if (ctrl_q == OP_LEFT) begin
        d[0] = q[WIDTH-1];
      end else if (ctrl_q == OP_RIGHT) begin
        d[WIDTH-1] = q[0];
      end
    end
  end
`else
  logic unused_rot;
  assign unused_rot = ^{cmd_rot, q};
  assign d          = dout_q;
`endif

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Scoreboard bench for shift_reg_sequencer with a behavioural downstream shift register.
module tb_shift_reg_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_fill = 1'b0;
  logic             cmd_rot = 1'b0;
  logic [WIDTH-1:0] q;
  logic [1:0]       ctrl;
  logic [WIDTH-1:0] d;
  logic             busy;
  logic             done;

  shift_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .cmd_fill(cmd_fill), .cmd_rot(cmd_rot), .q(q), .ctrl(ctrl), .d(d),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Downstream universal shift register.
  logic [WIDTH-1:0] sreg = '0;
  assign q = sreg;
  always @(posedge clk) begin
    case (ctrl)
      2'b01:   sreg <= {sreg[WIDTH-2:0], d[0]};
      2'b10:   sreg <= {d[WIDTH-1], sreg[WIDTH-1:1]};
      2'b11:   sreg <= d;
      default: sreg <= sreg;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]       ctrl;
    logic [WIDTH-1:0] d;
    logic             done;
    logic             busy;
    logic             ready;
    logic             chk_d;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-cycle output monitor: scoreboard entries first, otherwise idle outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("ctrl", 32'(ctrl), 32'(e.ctrl));
        if (e.chk_d) check_eq("d", 32'(d), 32'(e.d));
        check_eq("done", 32'(done), 32'(e.done));
        check_eq("busy", 32'(busy), 32'(e.busy));
        check_eq("cmd_ready", 32'(cmd_ready), 32'(e.ready));
      end else begin
        check_eq("idle_ctrl", 32'(ctrl), 32'd0);
        check_eq("idle_done", 32'(done), 32'd0);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input int cnt, input logic [WIDTH-1:0] data,
                       input logic fill, input logic rot, output int acc);
    int n;
    bit got;
    logic [WIDTH-1:0] dv;
    exp_t e;
    got = 1'b0;
    acc = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check_eq("ready_timeout", 32'd0, 32'd1);
      return;
    end
    cmd_op = op; cmd_count = CNT_W'(cnt); cmd_data = data;
    cmd_fill = fill; cmd_rot = rot; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    n = (op == 2'b11) ? 1 : cnt;
    case (op)
      2'b11:   dv = data;
      2'b01:   dv = WIDTH'(fill);
      2'b10:   dv = {fill, {(WIDTH-1){1'b0}}};
      default: dv = '0;
    endcase
    for (int i = 0; i < n; i++) begin
      e = '{ctrl: op, d: dv, done: 1'b0, busy: 1'b1, ready: 1'b0, chk_d: !rot};
      exp_q.push_back(e);
    end
    e = '{ctrl: 2'b00, d: '0, done: 1'b1, busy: 1'b1, ready: 1'b0, chk_d: 1'b1};
    exp_q.push_back(e);
    e = '{ctrl: 2'b00, d: '0, done: 1'b0, busy: 1'b0, ready: 1'b1, chk_d: 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) return;
    end
    check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  int acc1, acc2;

  initial begin
    // Reset held 3 cycles with a pending load command.
    reset = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_count = CNT_W'(7); cmd_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_ctrl", 32'(ctrl), 32'd0);
      check_eq("rst_d", 32'(d), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_ready", 32'(cmd_ready), 32'd0);
    end
    reset = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("post_rst_reg", 32'(sreg), 32'd0);
    mon_en = 1'b1;

    // Load ignores count.
    issue(2'b11, 7, 8'hA5, 1'b0, 1'b0, acc1);
    wait_drain();
    check_eq("reg_load", 32'(sreg), 32'hA5);

    issue(2'b01, 3, 8'h00, 1'b1, 1'b0, acc1);
    wait_drain();
    check_eq("reg_shl3", 32'(sreg), 32'h2F);

    issue(2'b10, 0, 8'h00, 1'b1, 1'b0, acc1);
    wait_drain();
    check_eq("reg_cnt0", 32'(sreg), 32'h2F);

    // Mid-operation reset after four shifts.
    issue(2'b11, 1, 8'hF0, 1'b0, 1'b0, acc1);
    wait_drain();
    issue(2'b10, 10, 8'h00, 1'b0, 1'b0, acc1);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_ctrl", 32'(ctrl), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready_rel", 32'(cmd_ready), 32'd1);
    check_eq("reg_midrst", 32'(sreg), 32'h0F);

    // Back-to-back: second acceptance exactly N+2 cycles after the first.
    issue(2'b01, 2, 8'h00, 1'b0, 1'b0, acc1);
    issue(2'b11, 5, 8'h3C, 1'b0, 1'b0, acc2);
    check_eq("b2b_gap", 32'(acc2 - acc1), 32'd4);
    wait_drain();
    check_eq("reg_b2b", 32'(sreg), 32'h3C);

    // Maximum count exceeds width.
    issue(2'b10, 15, 8'h00, 1'b1, 1'b0, acc1);
    wait_drain();
    check_eq("reg_cntmax", 32'(sreg), 32'hFF);

    issue(2'b00, 2, 8'h12, 1'b1, 1'b0, acc1);
    wait_drain();
    check_eq("reg_hold", 32'(sreg), 32'hFF);

`ifdef SEQ_ROTATE_EN
    issue(2'b11, 1, 8'h81, 1'b0, 1'b0, acc1);
    wait_drain();
    issue(2'b01, 1, 8'h00, 1'b0, 1'b1, acc1);
    wait_drain();
    check_eq("reg_rotl", 32'(sreg), 32'h03);
    issue(2'b10, 2, 8'h00, 1'b0, 1'b1, acc1);
    wait_drain();
    check_eq("reg_rotr", 32'(sreg), 32'hC0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
# shift_reg_sequencer

The shift register sequencer is a command-driven controller that sits directly upstream of the universal shift register. It accepts one operation per valid/ready handshake: hold, shift left, shift right, or parallel load. It then drives the register's `ctrl` and `d` inputs for the requested number of cycles and pulses `done` when the operation is complete. It turns multi-bit shift requests from a host or test FSM into the register's cycle-by-cycle control encoding.

## Interface
- `WIDTH`, default 8: data width. It matches the downstream register's width and must be at least 2.
- `CNT_W`, default 4: width of the repeat-count field.
- `clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-low reset.
- `cmd_valid` input, 1 bit: command present.
- `cmd_ready` output, 1 bit: the sequencer can accept a command.
- `cmd_op` input, 2 bits: operation. 00 = hold, 01 = shift left, 10 = shift right, 11 = load.
- `cmd_count` input, `CNT_W` bits: number of register cycles to issue. Ignored for load.
- `cmd_data` input, `WIDTH` bits: parallel load value.
- `cmd_fill` input, 1 bit: serial fill bit for shifts.
- `cmd_rot` input, 1 bit: rotate request. Only used when `SEQ_ROTATE_EN` is defined.
- `q` input, `WIDTH` bits: the downstream register's output. Only used when `SEQ_ROTATE_EN` is defined.
- `ctrl` output, 2 bits: control code to the downstream register.
- `d` output, `WIDTH` bits: data to the downstream register.
- `busy` output, 1 bit: a command is in progress (EXEC or DONE state).
- `done` output, 1 bit: one-cycle completion pulse.

## Operation
- **FSM states:** IDLE, EXEC, DONE.
- **IDLE**
  - `cmd_ready`=1, `ctrl`=00, `d`=0.
  - On `cmd_valid`&`cmd_ready`, the sequencer latches the op, count, data, fill and rot fields.
  - If the op is load, or the count is nonzero, the next state is EXEC.
  - If the op is hold, left or right with a count of 0, the next state is DONE directly. No register action is issued.
- **EXEC**
  - `ctrl` = the latched op.
  - An internal remaining-count register is loaded with the latched count (1 for load) and decrements once per EXEC cycle.
  - The FSM leaves for DONE on the cycle in which the remaining count equals 1.
- **`d` in EXEC:**
  - Load: `d` = latched data.
  - Shift left: `d[0]` = fill, all other bits 0.
  - Shift right: `d[WIDTH-1]` = fill, all other bits 0.
  - Hold: `d` = 0.
- **DONE:** `ctrl`=00, `d`=0, `done`=1, `cmd_ready`=0. The next state is always IDLE.
- `cmd_ready` is deasserted in EXEC and DONE. A `cmd_valid` seen outside IDLE is not consumed, and the command must be held until accepted.
- A count of all-ones (2^CNT_W−1) is legal, and the count may exceed `WIDTH`. The downstream register then simply shifts out all of its original bits.
- An undefined or latched-X op is treated as hold.
- **Reset** (`reset`=0 at a rising edge), from any state including mid-EXEC:
  - The FSM goes to IDLE, the remaining count goes to 0 and the latched fields are cleared.
  - Outputs after reset: `ctrl`=00, `d`=0, `done`=0, `busy`=0.
  - `cmd_ready` is 0 while `reset` is low and 1 on the first cycle after release.
  - A command presented during reset is not accepted.

## Timing
- A command is accepted at rising edge k.
- `ctrl` and `d` carry the op during cycles k+1 through k+N, where N = count (1 for load).
- `done`=1 during cycle k+N+1.
- `cmd_ready`=1 again in cycle k+N+2, so the earliest next acceptance is at the edge ending cycle k+N+2.
- For a count-0 command, `done` is high in cycle k+1 and `ctrl` never leaves 00.
- Back-to-back throughput is N+2 cycles per command.
- Every output is registered, except `d` in rotate mode (see Configuration).
- The downstream register therefore samples exactly N non-00 `ctrl` cycles per command.

## Configuration
- **Macro `SEQ_ROTATE_EN`:**
  - **Defined:** a shift command with `cmd_rot`=1 rotates instead of filling.
    - Shift left: `d[0]` is driven combinationally from `q[WIDTH-1]`.
    - Shift right: `d[WIDTH-1]` is driven combinationally from `q[0]`.
    - `cmd_rot` is ignored for hold and load.
  - **Not defined:**
    - The `cmd_rot` and `q` ports remain but are unused.
    - All outputs are registered.
    - Every shift uses `cmd_fill`.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `cmd_valid`=1. Required: `ctrl`=00, `d`=0, `done`=0, `busy`=0, no command accepted. After release, `cmd_ready`=1.
- **Load:** load with data 0xA5 and count 7. Required: exactly one cycle of `ctrl`=11 with `d`=0xA5, then `done` for one cycle. The downstream register reads 0xA5.
- **Shift left:** from register value 0xA5, shift left with count 3 and fill 1. Required: three cycles of `ctrl`=01 with `d`=0x01, then `done`. The register reads 0x2F.
- **Count zero:** shift right with count 0. Required: `done` in cycle k+1, `ctrl` stays 00, the register is unchanged.
- **Mid-operation reset and back-to-back:** start a shift right with count 10 and assert `reset` at EXEC cycle 4. Required: `ctrl`=00 and IDLE on the next cycle, with exactly 4 shifts having occurred. Then issue two back-to-back commands and check that the second is accepted exactly N+2 cycles after the first.
- **Rotate (`SEQ_ROTATE_EN`):** from register value 0x81, shift left with rot=1 and count 1. Required: the register reads 0x03. Then shift right with rot=1 and count 2. Required: the register reads 0xC0.
